// File: rtl/uart_pll_lock_sequencer.sv
// uart_pll_lock_sequencer
// Brings up the UART clock PLL: pulses its reset, waits for lock, qualifies
// lock stability, then releases the downstream reset. Lock loss in RUN
// re-resets the PLL. Lock timeouts and stability failures count as failed
// attempts, and exhausting them latches a sticky fault.
// Optional feature macro: UART_PLL_SEQ_STATUS_EN adds the loss_cnt port and a
// saturating lock-loss counter.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_PLL_RESET | pll_rst held high for RST_CYCLES cycles
// S_WAIT_LOCK | PLL released, waiting for synced lock (bounded by LOCK_TIMEOUT)
// S_STABLE    | counting consecutive synced-lock cycles up to STABLE_CYCLES
// S_RUN       | downstream logic released, ready=1
// S_FAULT     | retries exhausted; PLL and downstream held in reset until rst

module uart_pll_lock_sequencer #(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 5000,
    parameter int MAX_RETRIES   = 3
`ifdef UART_PLL_SEQ_STATUS_EN
    ,
    parameter int LOSS_CNT_W    = 8
`endif
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt
`ifdef UART_PLL_SEQ_STATUS_EN
    ,
    output logic [LOSS_CNT_W-1:0] loss_cnt
`endif
);

    localparam int T_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int T_MAX   = (T_MAX_A > STABLE_CYCLES) ? T_MAX_A : STABLE_CYCLES;
    localparam int TW      = $clog2(T_MAX + 1);
    localparam int RW      = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        S_PLL_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d, retry_inc;
    logic [1:0]    sync_q, sync_d;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_q, sys_rst_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;
    logic          locked_s;
    logic          fail;

    assign locked_s  = sync_q[1];
    assign retry_inc = retry_q + RW'(1);

    // Two-flop synchroniser for the asynchronous PLL lock output.
    always_comb begin
        sync_d = {sync_q[0], pll_locked};
    end

    // Next-state, timer and attempt bookkeeping; outputs decoded from next state.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        fail    = 1'b0;
        case (state_q)
            S_PLL_RESET: begin
                if (timer_q == TW'(RST_CYCLES - 1)) begin
                    state_d = S_WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_LOCK: begin
                // Lock seen on the timeout cycle still counts as lock.
                if (locked_s) begin
                    state_d = S_STABLE;
                    timer_d = '0;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    fail = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    fail = 1'b1;
                end else if (timer_q == TW'(STABLE_CYCLES - 1)) begin
                    state_d = S_RUN;
                    timer_d = '0;
                    retry_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RUN: begin
                // Loss of lock here is recovered without consuming an attempt.
                if (!locked_s) begin
                    state_d = S_PLL_RESET;
                    timer_d = '0;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_PLL_RESET;
                timer_d = '0;
            end
        endcase

        if (fail) begin
            retry_d = retry_inc;
            timer_d = '0;
            state_d = (retry_inc == RW'(MAX_RETRIES)) ? S_FAULT : S_PLL_RESET;
        end

        pll_rst_d = (state_d == S_PLL_RESET) || (state_d == S_FAULT);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fault_d   = fault_q || (state_d == S_FAULT);
    end

    // State, timer, synchroniser and registered outputs; rst overrides everything.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= S_PLL_RESET;
            timer_q   <= '0;
            retry_q   <= '0;
            sync_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            sync_q    <= sync_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = (retry_q > RW'(3)) ? 2'd3 : 2'(retry_q);

`ifdef UART_PLL_SEQ_STATUS_EN
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;

    // Count lock losses while running, holding at all-ones.
    always_comb begin
        loss_d = loss_q;
        if ((state_q == S_RUN) && !locked_s && (loss_q != '1)) begin
            loss_d = loss_q + LOSS_CNT_W'(1);
        end
    end

    // Lock-loss counter register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign loss_cnt = loss_q;
`else
    // No lock-loss status in this build.
`endif

endmodule
